serial_master: RTL and testbench

Initiator end of the daisy-chain single-wire serial control bus. Accepts a command (and optional data word) on a parallel valid/ready port, serialises it onto the bidirectional `data_inout` line as start bit + command + data, and for read commands releases the line and deserialises the word returned by the chain. It sits between the host-side register logic and the first `serial_ctrl` in the chain.

---
 rtl/serial_master_pkg.sv | 40 ++++
 rtl/serial_master_shifter.sv | 32 +++
 rtl/serial_master.sv | 192 +++++++++++++++++++
 tb/tb_serial_master.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_master_pkg.sv
// Shared definitions for the serial control bus initiator.
//   ctrl_cmd_t            - command encodings carried on the wire (MSB first)
//   serial_master_state_t - initiator FSM states
//   max_len()             - helper for sizing the shared bit counter
package serial_master_pkg;

    localparam int unsigned CMD_LEN  = 4;
    localparam int unsigned DATA_LEN = 8;

    typedef enum logic [CMD_LEN-1:0] {
        RESET_CMD     = 4'b1001,
        START_RCV_CMD = 4'b0110,
        START_SND_CMD = 4'b0101,
        UPDATE_CMD    = 4'b1100
    } ctrl_cmd_t;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StCmd,
        StCmdTail,
        StWGap,
        StWData,
        StWTail,
        StRGap,
        StRData,
        StRTurn
    } serial_master_state_t;

    function automatic int unsigned max_len(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/serial_master_shifter.sv
// Combined PISO/SIPO word register for the serial master.
//   clk, rst_n  - clock, synchronous active-low reset (clears the word)
//   load        - parallel load of load_val (wins over shift)
//   shift       - shift left one place, shift_in entering at the LSB
//   word        - current register contents; word[WIDTH-1] is the next bit out
module serial_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= load_val;
        end else if (shift) begin
            word_q <= {word_q[WIDTH-2:0], shift_in};
        end
    end

    assign word = word_q;

endmodule

// File: rtl/serial_master.sv
// Initiator of the single-wire daisy-chain control bus.
//   clk, rst_n           - clock, synchronous active-low reset
//   cmd_valid/cmd_ready  - host handshake; cmd and wdata captured on accept
//   rdata, rdata_valid   - last word read back, one-cycle update pulse
//   busy                 - high while a transfer is in flight
//   data_inout           - serial line: start bit, command, then write data or
//                          released for the chain to return read data
module serial_master #(
    parameter int unsigned CMD_LEN  = serial_master_pkg::CMD_LEN,
    parameter int unsigned DATA_LEN = serial_master_pkg::DATA_LEN,
    parameter int unsigned RCV_GAP  = 1,
    parameter int unsigned SND_GAP  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  serial_master_pkg::ctrl_cmd_t cmd,
    input  logic [DATA_LEN-1:0]          wdata,
    output logic [DATA_LEN-1:0]          rdata,
    output logic                         rdata_valid,
    output logic                         busy,
    inout  wire                          data_inout
);

    import serial_master_pkg::*;

    localparam int unsigned CntW = $clog2(max_len(CMD_LEN, DATA_LEN, SND_GAP, RCV_GAP) + 1);

    serial_master_state_t state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic [CMD_LEN-1:0]   cmd_sr_q;
    logic                 is_wr_q, is_rd_q;
    logic                 drive_en_q, drive_en_d;
    logic                 drive_bit_q, drive_bit_d;
    logic                 busy_q, busy_d;
    logic [DATA_LEN-1:0]  rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 rdata_load;

    logic                 accept;
    logic                 shift_cmd, shift_wr, shift_rd;
    logic [DATA_LEN-1:0]  word;

    assign cmd_ready = rst_n && (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the counter is loaded with length-1 on entry and the state exits at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d = StCmd;
                cnt_d   = CntW'(CMD_LEN - 1);
            end
            StCmd: begin
                if (cnt_q == '0) state_d = StCmdTail;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StCmdTail: begin
                if (is_wr_q) begin
                    if (RCV_GAP == 0) begin
                        state_d = StWData;
                        cnt_d   = CntW'(DATA_LEN - 1);
                    end else begin
                        state_d = StWGap;
                        cnt_d   = CntW'(RCV_GAP - 1);
                    end
                end else if (is_rd_q) begin
                    if (SND_GAP == 0) begin
                        state_d = StRData;
                        cnt_d   = CntW'(DATA_LEN - 1);
                    end else begin
                        state_d = StRGap;
                        cnt_d   = CntW'(SND_GAP - 1);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWGap: begin
                if (cnt_q == '0) begin
                    state_d = StWData;
                    cnt_d   = CntW'(DATA_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWData: begin
                if (cnt_q == '0) state_d = StWTail;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StWTail: state_d = StIdle;
            StRGap: begin
                if (cnt_q == '0) begin
                    state_d = StRData;
                    cnt_d   = CntW'(DATA_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRData: begin
                if (cnt_q == '0) state_d = StRTurn;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StRTurn: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: line drive is computed for the upcoming state so it lands registered
    always_comb begin
        shift_cmd     = (state_q == StCmd);
        shift_wr      = (state_q == StWData);
        shift_rd      = (state_q == StRData);
        drive_en_d    = !(state_d inside {StRGap, StRData, StRTurn});
        drive_bit_d   = 1'b0;
        busy_d        = (state_d != StIdle);
        rdata_valid_d = (state_d == StRTurn);
        rdata_load    = (state_q == StRData) && (state_d == StRTurn);
        // Final sample enters directly here; the shifter still holds the earlier bits
        rdata_d       = {word[DATA_LEN-2:0], data_inout};
        case (state_d)
            StStart: drive_bit_d = 1'b1;
            // When the register shifts at this edge, the bit below the MSB becomes next
            StCmd:   drive_bit_d = shift_cmd ? cmd_sr_q[CMD_LEN-2] : cmd_sr_q[CMD_LEN-1];
            StWData: drive_bit_d = shift_wr ? word[DATA_LEN-2] : word[DATA_LEN-1];
            default: drive_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_sr_q      <= '0;
            is_wr_q       <= 1'b0;
            is_rd_q       <= 1'b0;
            drive_en_q    <= 1'b1;
            drive_bit_q   <= 1'b0;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_sr_q <= cmd;
                is_wr_q  <= (cmd == START_RCV_CMD);
                is_rd_q  <= (cmd == START_SND_CMD);
            end else if (shift_cmd) begin
                cmd_sr_q <= {cmd_sr_q[CMD_LEN-2:0], 1'b0};
            end
            drive_en_q    <= drive_en_d;
            drive_bit_q   <= drive_bit_d;
            busy_q        <= busy_d;
            rdata_valid_q <= rdata_valid_d;
            if (rdata_load) rdata_q <= rdata_d;
        end
    end

    serial_shifter #(
        .WIDTH (DATA_LEN)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (wdata),
        .shift    (shift_wr || shift_rd),
        .shift_in (shift_rd ? data_inout : 1'b0),
        .word     (word)
    );

    assign data_inout  = drive_en_q ? drive_bit_q : 1'bz;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_serial_master.sv
// Directed bench for serial_master (CMD_LEN=4, DATA_LEN=8, RCV_GAP=1, SND_GAP=2).
// A pullup on the line makes master-released cycles read as 1; the bench plays the
// responder by driving read data during the read-data window.
module tb_serial_master;

    import serial_master_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    ctrl_cmd_t   cmd;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        busy;
    wire         data_inout;

    logic        tb_en;
    logic        tb_bit;

    int n_checks;
    int n_fail;

    assign data_inout = tb_en ? tb_bit : 1'bz;
    pullup (data_inout);

    serial_master #(
        .CMD_LEN  (4),
        .DATA_LEN (8),
        .RCV_GAP  (1),
        .SND_GAP  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .data_inout  (data_inout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call just after a rising edge with the DUT idle. Bit k of each vector is the
    // value sampled in cycle k after the accept edge.
    task automatic xfer(input logic [3:0] c, input logic [7:0] wd, input logic [7:0] resp,
                        input int n, output logic [31:0] line_v, output logic [31:0] busy_v,
                        output logic [31:0] vld_v, output logic [31:0] rdy_v);
        line_v = '0; busy_v = '0; vld_v = '0; rdy_v = '0;
        cmd_valid = 1'b1;
        cmd       = ctrl_cmd_t'(c);
        wdata     = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = ctrl_cmd_t'(~c);
        wdata     = ~wd;
        for (int k = 1; k <= n; k++) begin
            if (c == START_SND_CMD && k >= 9 && k <= 16) begin
                tb_en  = 1'b1;
                tb_bit = resp[16-k];
            end else begin
                tb_en = 1'b0;
            end
            @(negedge clk);
            line_v[k] = data_inout;
            busy_v[k] = busy;
            vld_v[k]  = rdata_valid;
            rdy_v[k]  = cmd_ready;
            @(posedge clk);
            #1;
        end
        tb_en = 1'b0;
    endtask

    logic [31:0] line_v, busy_v, vld_v, rdy_v, acc_v;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = RESET_CMD;
        wdata     = 8'h00;
        tb_en     = 1'b0;
        tb_bit    = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_line", 32'(data_inout), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        check_eq("rst_valid", 32'(rdata_valid), 32'h0);
        check_eq("rst_ready_low", 32'(cmd_ready), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready_after", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;

        // RESET_CMD 1001: 1, 1,0,0,1, 0 then idle
        xfer(RESET_CMD, 8'h00, 8'h00, 8, line_v, busy_v, vld_v, rdy_v);
        check_eq("reset_line", line_v, 32'h026);
        check_eq("reset_busy", busy_v, 32'h07E);
        check_eq("reset_valid", vld_v, 32'h0);
        check_eq("reset_ready", rdy_v, 32'h180);

        // Write A5: data in cycles 8..15, tail 16, busy 16 cycles
        xfer(START_RCV_CMD, 8'hA5, 8'h00, 18, line_v, busy_v, vld_v, rdy_v);
        check_eq("write_line", line_v, 32'h0A51A);
        check_eq("write_busy", busy_v, 32'h1FFFE);
        check_eq("write_valid", vld_v, 32'h0);
        check_eq("write_ready", rdy_v, 32'h60000);

        // UPDATE_CMD 1100
        xfer(UPDATE_CMD, 8'h00, 8'h00, 8, line_v, busy_v, vld_v, rdy_v);
        check_eq("update_line", line_v, 32'h00E);
        check_eq("update_busy", busy_v, 32'h07E);

        // Read A5: released 7..8, responder 9..16, RTURN 17 released, 18 driven 0
        xfer(START_SND_CMD, 8'h00, 8'hA5, 19, line_v, busy_v, vld_v, rdy_v);
        check_eq("read_line", line_v, 32'h34BAA);
        check_eq("read_busy", busy_v, 32'h3FFFE);
        check_eq("read_valid", vld_v, 32'h20000);
        check_eq("read_ready", rdy_v, 32'hC0000);
        check_eq("read_rdata_a5", 32'(rdata), 32'hA5);

        xfer(START_SND_CMD, 8'h00, 8'h3C, 19, line_v, busy_v, vld_v, rdy_v);
        check_eq("read_rdata_3c", 32'(rdata), 32'h3C);
        check_eq("read2_valid", vld_v, 32'h20000);

        // Back-to-back with cmd_valid held: accepts at cycle 0 and first idle cycle 7
        acc_v     = '0;
        line_v    = '0;
        cmd_valid = 1'b1;
        cmd       = RESET_CMD;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            acc_v[k]  = cmd_valid && cmd_ready;
            line_v[k] = data_inout;
            @(posedge clk);
            #1;
            if (k == 0) cmd = UPDATE_CMD;
            else if (acc_v[k]) cmd_valid = 1'b0;
        end
        check_eq("b2b_accepts", acc_v, 32'h081);
        check_eq("b2b_line", line_v, 32'h326);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("b2b_done_busy", 32'(busy), 32'h0);
        check_eq("b2b_done_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;

        // Reset during WDATA bit 3 (cycle 11) of a B4 write
        cmd_valid = 1'b1;
        cmd       = START_RCV_CMD;
        wdata     = 8'hB4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mid_bit3", 32'(data_inout), 32'h1);
        check_eq("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_line", 32'(data_inout), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_valid", 32'(rdata_valid), 32'h0);
        check_eq("mid_rst_rdata", 32'(rdata), 32'h0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;

        xfer(RESET_CMD, 8'h00, 8'h00, 8, line_v, busy_v, vld_v, rdy_v);
        check_eq("post_rst_line", line_v, 32'h026);
        check_eq("post_rst_busy", busy_v, 32'h07E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
